riscv_dmem_responder: RTL

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

---
 rtl/riscv_dmem_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: single-port data memory answering one RISC-V load/store at a time with optional wait states.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, be;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word, bsel, wd, rdata_q, rdata_n;
  logic [15:0] hsel;
  logic [AW-1:0] idx;
  logic accept, err, err_q;
  assign req_ready = state == IDLE && !rst;
  assign rsp_valid = state == RESP && !rst;
  assign rsp_rdata = rst ? '0 : rdata_q;
  assign rsp_err   = !rst && err_q;
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];
  assign err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
               ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign word = mem[idx];
  assign bsel = word >> {req_addr[1:0], 3'b000};
  assign hsel = req_addr[1] ? word[31:16] : word[15:0];
  // Load result is extended here so the response register already holds the final value.
  assign rdata_n = (err || req_we) ? '0 :
                   req_size == 2'b00 ? {{24{~req_unsigned & bsel[7]}}, bsel[7:0]} :
                   req_size == 2'b01 ? {{16{~req_unsigned & hsel[15]}}, hsel} : word;
  assign wd = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
              req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign be = req_size == 2'b00 ? 4'(4'b0001 << req_addr[1:0]) :
              req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == IDLE && accept) begin
      state_n = WAIT_STATES == 0 ? RESP : BUSY;
      cnt_n = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
    end else if (state == BUSY) begin
      state_n = cnt == 4'd0 ? RESP : BUSY;
      cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end else if (state == RESP && rsp_ready) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        rdata_q <= rdata_n;
        err_q <= err;
      end
    end
  end
  // Storage is deliberately outside the reset domain: contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule
